// File: rtl/weight_buffer_read_control.sv
// Read-side sequencer for the weight line buffers.
// Streams base..base+count-1 (mod depth) from one line buffer, repeated
// (repeat+1) times, through a small first-word-fall-through FIFO that
// absorbs the RAM read latency while the PE array applies backpressure.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start; command inputs latched on acceptance
// READ  | issuing RAM reads while the FIFO has room for every word in flight
// DRAIN | all reads issued; waiting for the last word to be accepted
// DONE  | one-cycle completion pulse, then back to IDLE
module weight_buffer_read_control #(
    parameter int WEIGHT_BANK_BIT_WIDTH         = 64,
    parameter int WEIGHT_BUFFER_BANK_COUNT      = 4,
    parameter int WEIGHT_LINE_BUFFER_DEPTH      = 512,
    parameter int NUMBER_OF_WEIGHT_LINE_BUFFERS = 2,
    parameter int RAM_OUTPUT_PIPES              = 1,
    localparam int ADDR_W = $clog2(WEIGHT_LINE_BUFFER_DEPTH),
    localparam int SEL_W  = (NUMBER_OF_WEIGHT_LINE_BUFFERS > 1) ? $clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS) : 1,
    localparam int LINE_W = WEIGHT_BUFFER_BANK_COUNT * WEIGHT_BANK_BIT_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            i_start,
    input  logic [ADDR_W-1:0]                               i_base_addr,
    input  logic [ADDR_W:0]                                 i_word_count,
    input  logic [15:0]                                     i_repeat_count,
    input  logic [SEL_W-1:0]                                i_line_buffer_sel,
    output logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0]        o_read_enable,
    output logic [ADDR_W-1:0]                               o_read_addr,
    input  logic [NUMBER_OF_WEIGHT_LINE_BUFFERS*LINE_W-1:0] i_read_data,
    output logic [LINE_W-1:0]                               o_weight_data,
    output logic                                            o_weight_valid,
    input  logic                                            i_weight_ready,
    output logic                                            o_weight_last,
    output logic                                            o_busy,
    output logic                                            o_done
);

    localparam int P          = RAM_OUTPUT_PIPES;
    localparam int FIFO_DEPTH = RAM_OUTPUT_PIPES + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   base_q, addr_q, addr_inc;
    logic [ADDR_W:0]     count_q, word_q, word_next;
    logic [15:0]         repeat_q;
    logic [SEL_W-1:0]    sel_q;
    logic [P-1:0]        pipe_v, pipe_last;
    logic [CNT_W-1:0]    in_flight, fifo_count;
    logic [CNT_W:0]      occupancy;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LINE_W:0]     fifo_mem [FIFO_DEPTH];
    logic [LINE_W:0]     fifo_head;
    logic                issue, pass_end, final_issue, push, pop;

    // Words still travelling through the RAM read pipeline.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < P; i++) begin
            in_flight = in_flight + CNT_W'(pipe_v[i]);
        end
    end

    // A read is only issued when the FIFO can hold it plus everything in flight,
    // so a stalled consumer can never overflow the FIFO. A same-cycle pop is not credited.
    assign occupancy   = {1'b0, fifo_count} + {1'b0, in_flight};
    assign issue       = (state == READ) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign word_next   = word_q + (ADDR_W + 1)'(1);
    assign pass_end    = (word_next == count_q);
    assign final_issue = issue && pass_end && (repeat_q == 16'd0);
    assign addr_inc    = (addr_q == ADDR_W'(WEIGHT_LINE_BUFFER_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    assign push = pipe_v[P-1];
    assign pop  = (fifo_count != '0) && i_weight_ready;

    // Next-state and command outputs.
    always_comb begin
        state_next    = state;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_read_enable = '0;
        o_read_addr   = '0;
        if (issue) begin
            o_read_enable[sel_q] = 1'b1;
            o_read_addr          = addr_q;
        end
        case (state)
            IDLE: begin
                // A zero-length command passes through DRAIN so it still shows one busy cycle.
                if (i_start) state_next = (i_word_count == '0) ? DRAIN : READ;
            end
            READ: begin
                o_busy = 1'b1;
                if (final_issue) state_next = DRAIN;
            end
            DRAIN: begin
                o_busy = 1'b1;
                if ((in_flight == '0) && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)))
                    state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Command latch plus address / pass / repeat bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q   <= '0;
            count_q  <= '0;
            repeat_q <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
            word_q   <= '0;
        end else if ((state == IDLE) && i_start) begin
            base_q   <= i_base_addr;
            count_q  <= i_word_count;
            repeat_q <= i_repeat_count;
            sel_q    <= i_line_buffer_sel;
            addr_q   <= i_base_addr;
            word_q   <= '0;
        end else if (issue) begin
            if (pass_end) begin
                word_q <= '0;
                if (repeat_q != 16'd0) begin
                    addr_q   <= base_q;
                    repeat_q <= repeat_q - 16'd1;
                end
            end else begin
                word_q <= word_next;
                addr_q <= addr_inc;
            end
        end
    end

    // Read-latency pipe and FIFO pointers; reset discards anything still returning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v     <= '0;
            pipe_last  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            pipe_v[0]    <= issue;
            pipe_last[0] <= final_issue;
            for (int i = 1; i < P; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage: the selected buffer's slice plus its last tag.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pipe_last[P-1], i_read_data[int'(sel_q)*LINE_W +: LINE_W]};
    end

    assign fifo_head      = fifo_mem[rd_ptr];
    assign o_weight_valid = (fifo_count != '0);
    assign o_weight_data  = o_weight_valid ? fifo_head[LINE_W-1:0] : '0;
    assign o_weight_last  = o_weight_valid & fifo_head[LINE_W];

endmodule

// File: tb/tb_weight_buffer_read_control.sv
// Directed bench for weight_buffer_read_control with a behavioural RAM.
module tb_weight_buffer_read_control;

    localparam int BW     = 64;
    localparam int NB     = 4;
    localparam int DEPTH  = 512;
    localparam int NLB    = 2;
    localparam int P      = 1;
    localparam int LINE_W = BW * NB;
    localparam int ADDR_W = 9;
    localparam int FD     = P + 2;

    typedef logic [LINE_W-1:0] vec_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    i_start;
    logic [ADDR_W-1:0]       i_base_addr;
    logic [ADDR_W:0]         i_word_count;
    logic [15:0]             i_repeat_count;
    logic [0:0]              i_line_buffer_sel;
    logic [NLB-1:0]          o_read_enable;
    logic [ADDR_W-1:0]       o_read_addr;
    logic [NLB*LINE_W-1:0]   i_read_data = '0;
    logic [LINE_W-1:0]       o_weight_data;
    logic                    o_weight_valid;
    logic                    i_weight_ready;
    logic                    o_weight_last;
    logic                    o_busy;
    logic                    o_done;

    weight_buffer_read_control #(
        .WEIGHT_BANK_BIT_WIDTH(BW),
        .WEIGHT_BUFFER_BANK_COUNT(NB),
        .WEIGHT_LINE_BUFFER_DEPTH(DEPTH),
        .NUMBER_OF_WEIGHT_LINE_BUFFERS(NLB),
        .RAM_OUTPUT_PIPES(P)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_word_count(i_word_count), .i_repeat_count(i_repeat_count),
        .i_line_buffer_sel(i_line_buffer_sel), .o_read_enable(o_read_enable),
        .o_read_addr(o_read_addr), .i_read_data(i_read_data), .o_weight_data(o_weight_data),
        .o_weight_valid(o_weight_valid), .i_weight_ready(i_weight_ready),
        .o_weight_last(o_weight_last), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t ram_word(input int b, input int a);
        vec_t w;
        for (int j = 0; j < NB; j++) w[j*BW +: BW] = {8'(8'hA0 + b), 8'(j), 16'h5A5A, 32'(a)};
        return w;
    endfunction

    // RAM model with one cycle of read latency.
    always @(posedge clk) begin
        for (int k = 0; k < NLB; k++)
            if (o_read_enable[k]) i_read_data[k*LINE_W +: LINE_W] <= ram_word(k, int'(o_read_addr));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready: always 1, or the repeating 1-0-0-1 pattern.
    int       rdy_mode = 0;
    int       rdy_idx  = 0;
    bit [3:0] rdy_pat  = 4'b1001;
    initial begin
        i_weight_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) i_weight_ready = 1'b1;
            else begin
                i_weight_ready = rdy_pat[rdy_idx];
                rdy_idx = (rdy_idx + 1) % 4;
            end
        end
    end

    // Monitor: records reads, accepted words and protocol events.
    int   addr_q[$];
    int   en_q[$];
    vec_t data_q[$];
    bit   last_q[$];
    int   issued, accepted, done_seen, busy_cycles, max_out;
    int   first_rd, first_val, last_acc, done_cyc;
    bit   prev_stall;
    vec_t prev_data;
    bit   prev_last;

    task automatic clear_mon();
        addr_q.delete(); en_q.delete(); data_q.delete(); last_q.delete();
        issued = 0; accepted = 0; done_seen = 0; busy_cycles = 0; max_out = 0;
        first_rd = -1; first_val = -1; last_acc = -1; done_cyc = -1;
    endtask

    always @(negedge clk) begin
        if (reset) prev_stall = 1'b0;
        else begin
            if (o_read_enable != '0) begin
                en_q.push_back(int'(o_read_enable));
                addr_q.push_back(int'(o_read_addr));
                issued++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (o_weight_valid && first_val < 0) first_val = cyc;
            if (prev_stall) begin
                chk("stall_valid", vec_t'(o_weight_valid), vec_t'(1));
                chk("stall_data", o_weight_data, prev_data);
                chk("stall_last", vec_t'(o_weight_last), vec_t'(prev_last));
            end
            if (o_weight_valid && i_weight_ready) begin
                data_q.push_back(o_weight_data);
                last_q.push_back(o_weight_last);
                accepted++;
                last_acc = cyc;
            end
            if (o_done) begin done_seen++; done_cyc = cyc; end
            if (o_busy) busy_cycles++;
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = o_weight_valid && !i_weight_ready;
            prev_data  = o_weight_data;
            prev_last  = o_weight_last;
        end
    end

    // Entered just after a posedge; returns on the posedge closing the o_done cycle.
    task automatic run_cmd(input int base, input int cnt, input int rep, input int sel,
                           input int mode, input bit inject, input string tag);
        int total, start_c, iter, ea;
        total = cnt * (rep + 1);
        clear_mon();
        rdy_mode = mode;
        #1;
        i_base_addr       = ADDR_W'(base);
        i_word_count      = (ADDR_W + 1)'(cnt);
        i_repeat_count    = 16'(rep);
        i_line_buffer_sel = 1'(sel);
        i_start           = 1'b1;
        @(posedge clk);
        #1;
        start_c = cyc - 1;
        i_start = 1'b0;
        iter = 0;
        while (done_seen == 0 && iter < 3000) begin
            @(posedge clk);
            iter++;
            if (inject && iter == 3) begin
                #1;
                i_start = 1'b1;
                i_base_addr = ADDR_W'(base + 77);
                i_word_count = 2;
                i_line_buffer_sel = 1'(1 - sel);
            end else if (inject && iter == 4) begin
                #1;
                i_start = 1'b0;
            end
        end
        chk({tag, "_done_count"}, vec_t'(done_seen), vec_t'(1));
        chk({tag, "_issued"}, vec_t'(issued), vec_t'(total));
        chk({tag, "_accepted"}, vec_t'(accepted), vec_t'(total));
        chk({tag, "_max_outstanding_ok"}, vec_t'(max_out <= FD), vec_t'(1));
        for (int i = 0; i < total; i++) begin
            ea = (base + (i % cnt)) % DEPTH;
            if (i < addr_q.size()) begin
                chk({tag, "_addr"}, vec_t'(addr_q[i]), vec_t'(ea));
                chk({tag, "_enable"}, vec_t'(en_q[i]), vec_t'(1 << sel));
            end
            if (i < data_q.size()) begin
                chk({tag, "_data"}, data_q[i], ram_word(sel, ea));
                chk({tag, "_last"}, vec_t'(last_q[i]), vec_t'(i == total - 1));
            end
        end
        if (total == 0) begin
            chk({tag, "_busy_cycles"}, vec_t'(busy_cycles), vec_t'(1));
            chk({tag, "_no_valid"}, vec_t'(first_val < 0), vec_t'(1));
        end else if (mode == 0) begin
            chk({tag, "_first_read_lat"}, vec_t'(first_rd - start_c), vec_t'(1));
            chk({tag, "_first_valid_lat"}, vec_t'(first_val - start_c), vec_t'(3));
            chk({tag, "_done_after_last"}, vec_t'(done_cyc - last_acc), vec_t'(1));
        end
    endtask

    initial begin
        int iter;
        reset = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_word_count = '0;
        i_repeat_count = '0;
        i_line_buffer_sel = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", vec_t'(o_weight_valid), vec_t'(0));
        chk("rst_enable", vec_t'(o_read_enable), vec_t'(0));
        chk("rst_busy", vec_t'(o_busy), vec_t'(0));
        chk("rst_done", vec_t'(o_done), vec_t'(0));
        chk("rst_data", o_weight_data, vec_t'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        run_cmd(10, 4, 0, 1, 0, 1'b0, "basic");
        run_cmd(510, 3, 2, 1, 0, 1'b0, "wrap");
        run_cmd(200, 16, 0, 0, 1, 1'b0, "backpressure");
        run_cmd(7, 0, 0, 0, 0, 1'b0, "zero");
        run_cmd(40, 12, 0, 1, 0, 1'b1, "busy_start");
        run_cmd(60, 3, 0, 0, 0, 1'b0, "back_to_back");

        // Reset in the middle of a 20-word transfer.
        clear_mon();
        rdy_mode = 0;
        #1;
        i_base_addr = 100; i_word_count = 20; i_repeat_count = 0; i_line_buffer_sel = 0;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        iter = 0;
        while (accepted < 5 && iter < 200) begin
            @(posedge clk);
            iter++;
        end
        chk("midrst_reached_word5", vec_t'(accepted >= 5), vec_t'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", vec_t'(o_weight_valid), vec_t'(0));
        chk("midrst_enable", vec_t'(o_read_enable), vec_t'(0));
        chk("midrst_busy", vec_t'(o_busy), vec_t'(0));
        chk("midrst_last", vec_t'(o_weight_last), vec_t'(0));
        chk("midrst_data", o_weight_data, vec_t'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", vec_t'(done_seen), vec_t'(0));
        chk("midrst_idle_valid", vec_t'(o_weight_valid), vec_t'(0));
        chk("midrst_idle_busy", vec_t'(o_busy), vec_t'(0));
        run_cmd(300, 5, 1, 1, 0, 1'b0, "post_reset");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
